// File: rtl/xswitch_pkg.sv
// xswitch_pkg
// Shared constants and types for the xswitch datapath. The ingress stage,
// the per-output arbiters and the testbench scoreboard all use these.
//   NUM_PORTS   : number of switch ports
//   ADDR_W      : width of a port address
//   DATA_W      : payload width
//   port_addr_t : a port address
//   xsw_entry_t : one buffered word, tagged with the input port it came from
package xswitch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = $clog2(NUM_PORTS);
  localparam int DATA_W    = 8;

  typedef logic [ADDR_W-1:0] port_addr_t;

  typedef struct packed {
    port_addr_t        src;
    logic [DATA_W-1:0] data;
  } xsw_entry_t;

  // Next port index in round-robin order, wrapping at numPorts even when
  // numPorts is not a power of two.
  function automatic port_addr_t nextPort(input port_addr_t p, input int numPorts);
    return (p == port_addr_t'(numPorts - 1)) ? port_addr_t'(0) : port_addr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/xswitch_out_arbiter_if.sv
// xswitch_out_arbiter_if
// Bundles the ingress request bus and the egress valid/ready bus seen by one
// output-port arbiter.
//   in_valid/in_addr/in_data : per-input requests, slice i at [i*W +: W]
//   in_ready                 : per-input grant, one-hot or zero
//   out_valid/out_data/out_src/out_ready : egress handshake
//   fifo_count               : output buffer occupancy
// The master modport drives requests and accepts output words; the slave
// modport is the arbiter.
interface xswitch_out_arbiter_if #(
  parameter int NUM_PORTS  = xswitch_pkg::NUM_PORTS,
  parameter int ADDR_W     = xswitch_pkg::ADDR_W,
  parameter int DATA_W     = xswitch_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8
);

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*ADDR_W-1:0] in_addr;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_ready;

  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [ADDR_W-1:0]           out_src;
  logic                        out_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, fifo_count
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, fifo_count
  );

endinterface

// File: rtl/xswitch_sync_fifo.sv
// xswitch_sync_fifo
// Synchronous first-word-fall-through FIFO: rdata always shows the entry at
// the read pointer, so a word pushed into an empty FIFO is visible on the
// next cycle.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write request and data, ignored while full
//   pop        : read request, ignored while empty
//   rdata      : head entry (content undefined while empty)
//   full/empty : status flags
//   count      : occupancy, 0..DEPTH
module xswitch_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rdata  = mem[rdPtr_q];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Next-state for pointers and occupancy; a simultaneous push and pop
  // leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything buffered and blocks any
  // push or pop requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; stale entries are unreachable
  // once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (doPush && !reset) begin
      mem[wrPtr_q] <= wdata;
    end
  end

endmodule

// File: rtl/xswitch_out_arbiter.sv
// xswitch_out_arbiter
// Per-output-port stage of the xswitch. Picks the inputs whose destination
// equals PORT_ID, grants one of them per cycle in round-robin order and
// buffers the accepted words in an FWFT FIFO feeding a valid/ready output.
//   clk, reset : clock and synchronous active-high reset
//   bus        : xswitch_out_arbiter_if slave modport carrying the request
//                bus (in_valid/in_addr/in_data/in_ready) and the output bus
//                (out_valid/out_data/out_src/out_ready/fifo_count)
// NUM_PORTS, ADDR_W and DATA_W must match xswitch_pkg because the buffered
// entry uses xsw_entry_t.
module xswitch_out_arbiter
  import xswitch_pkg::*;
#(
  parameter int NUM_PORTS  = xswitch_pkg::NUM_PORTS,
  parameter int ADDR_W     = xswitch_pkg::ADDR_W,
  parameter int DATA_W     = xswitch_pkg::DATA_W,
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  xswitch_out_arbiter_if.slave  bus
);

  localparam port_addr_t MY_ADDR = port_addr_t'(PORT_ID);

  logic [NUM_PORTS-1:0]          req;
  port_addr_t                    rrPtr_q;
  port_addr_t                    grantIdx;
  port_addr_t                    scanIdx;
  logic                          grantFound;
  logic                          grantOk;
  logic                          pushEn;
  logic                          popEn;
  logic                          fifoFull;
  logic                          fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]   fifoCount;
  xsw_entry_t                    wrEntry;
  xsw_entry_t                    rdEntry;

  // Request decode. in_valid gates the address compare so an undriven
  // address on an idle input cannot reach the grant.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = bus.in_valid[i] && (bus.in_addr[i*ADDR_W +: ADDR_W] == MY_ADDR);
    end
  end

  // Round-robin search starting just after the last granted port, so the
  // most recent winner has the lowest priority next time.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = rrPtr_q;
    scanIdx    = rrPtr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scanIdx = nextPort(scanIdx, NUM_PORTS);
      if (!grantFound && req[scanIdx]) begin
        grantFound = 1'b1;
        grantIdx   = scanIdx;
      end
    end
  end

  // Full blocks the grant even if the head is popped this cycle; there is
  // no bypass path from pop to push.
  assign grantOk = grantFound && !fifoFull && !reset;

  always_comb begin
    bus.in_ready = '0;
    if (grantOk) begin
      bus.in_ready[grantIdx] = 1'b1;
    end
  end

  assign pushEn       = |(bus.in_valid & bus.in_ready);
  assign popEn        = bus.out_valid && bus.out_ready;
  assign wrEntry.src  = grantIdx;
  assign wrEntry.data = bus.in_data[grantIdx*DATA_W +: DATA_W];

  // Round-robin pointer follows the last accepted port. Starting at
  // NUM_PORTS-1 gives port 0 first priority after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= port_addr_t'(NUM_PORTS - 1);
    end else if (pushEn) begin
      rrPtr_q <= grantIdx;
    end
  end

  xswitch_sync_fifo #(
    .WIDTH ($bits(xsw_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushEn),
    .pop   (popEn),
    .wdata (wrEntry),
    .rdata (rdEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Output data is forced to zero while nothing is buffered so stale
  // storage never shows on the bus.
  assign bus.out_valid  = !fifoEmpty;
  assign bus.out_data   = fifoEmpty ? '0 : rdEntry.data;
  assign bus.out_src    = fifoEmpty ? '0 : rdEntry.src;
  assign bus.fifo_count = fifoCount;

endmodule

// File: tb/tb_xswitch_out_arbiter.sv
// tb_xswitch_out_arbiter
// Randomised and directed stimulus for one output arbiter. A reference model
// tracks the round-robin winner and FIFO occupancy; every accepted word is
// queued as the expected output and a separate monitor compares each word the
// DUT hands off against the head of that queue.
module tb_xswitch_out_arbiter;
  import xswitch_pkg::*;

  localparam int NP    = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int PID   = 0;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  xswitch_out_arbiter_if #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .FIFO_DEPTH (DEPTH)
  ) bus ();

  xswitch_out_arbiter #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .PORT_ID (PID), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  xsw_entry_t  expQ[$];
  int          lastGrant   = NP - 1;
  int          modelCount  = 0;
  int          expGrant    = -1;
  bit          monitorOn   = 1'b0;

  logic [NP-1:0] stimValid;
  logic [AW-1:0] stimAddr [NP];
  logic [DW-1:0] stimData [NP];
  logic          stimReady;
  logic          stimReset;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Winner per the arbitration rule: first requester after the last winner,
  // nothing if the buffer is full or reset is held.
  function automatic int modelGrant();
    if (stimReset || modelCount >= DEPTH) return -1;
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (lastGrant + k) % NP;
      if (stimValid[p] && stimAddr[p] == AW'(PID)) return p;
    end
    return -1;
  endfunction

  task automatic setIdle();
    stimValid = '0;
    for (int p = 0; p < NP; p++) begin
      stimAddr[p] = AW'($urandom_range(0, NP - 1));
      stimData[p] = DW'($urandom);
    end
    stimReady = 1'b1;
    stimReset = 1'b0;
  endtask

  // One clock cycle: drive, check control outputs mid-cycle, then advance
  // the reference model at the clock edge.
  task automatic applyStimulus();
    logic [NP-1:0] expReady;
    xsw_entry_t    e;
    bit            popNow;
    reset         = stimReset;
    bus.out_ready = stimReady;
    for (int p = 0; p < NP; p++) begin
      bus.in_valid[p]          = stimValid[p];
      bus.in_addr[p*AW +: AW]  = stimAddr[p];
      bus.in_data[p*DW +: DW]  = stimData[p];
    end
    expGrant = modelGrant();
    expReady = (expGrant >= 0) ? (NP'(1) << expGrant) : '0;
    @(negedge clk);
    checkOutput("in_ready",   32'(bus.in_ready),   32'(expReady));
    checkOutput("out_valid",  32'(bus.out_valid),  (modelCount != 0) ? 32'd1 : 32'd0);
    checkOutput("fifo_count", 32'(bus.fifo_count), 32'(modelCount));
    @(posedge clk);
    if (stimReset) begin
      modelCount = 0;
      lastGrant  = NP - 1;
      expQ.delete();
    end else begin
      popNow = (modelCount > 0) && stimReady;
      if (expGrant >= 0) begin
        e.src  = port_addr_t'(expGrant);
        e.data = stimData[expGrant];
        expQ.push_back(e);
        lastGrant  = expGrant;
        modelCount = modelCount + 1;
      end
      if (popNow) modelCount = modelCount - 1;
    end
    #1;
  endtask

  task automatic idleCycles(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      setIdle();
      stimReady = ready;
      applyStimulus();
    end
  endtask

  // Monitor: compares the head word whenever the DUT presents one and pops
  // the expected queue on each handshake.
  initial begin
    xsw_entry_t e;
    forever begin
      @(negedge clk);
      if (monitorOn && !reset) begin
        if (bus.out_valid) begin
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_word: got data 0x%0h src %0d, expected none",
                     bus.out_data, bus.out_src);
          end else begin
            e = expQ[0];
            checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
            checkOutput("out_src",  32'(bus.out_src),  32'(e.src));
            if (bus.out_ready) void'(expQ.pop_front());
          end
        end else begin
          checkOutput("out_data_idle", 32'(bus.out_data), 32'd0);
          checkOutput("out_src_idle",  32'(bus.out_src),  32'd0);
        end
      end
    end
  end

  initial begin
    int w;
    int cyc;

    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    monitorOn = 1'b1;

    // Reset held, then idle.
    setIdle();
    stimReset = 1'b1;
    applyStimulus();
    idleCycles(5, 1'b1);

    // Single word from port 2.
    setIdle();
    stimValid[2] = 1'b1;
    stimAddr[2]  = AW'(PID);
    stimData[2]  = 8'hA5;
    applyStimulus();
    idleCycles(3, 1'b1);

    // All ports contend continuously.
    for (int c = 0; c < 12; c++) begin
      setIdle();
      for (int p = 0; p < NP; p++) begin
        stimValid[p] = 1'b1;
        stimAddr[p]  = AW'(PID);
        stimData[p]  = DW'(8'h10 + p);
      end
      applyStimulus();
    end
    idleCycles(3, 1'b1);

    // Port 1 streams ten words into a stalled output, then drains.
    w   = 0;
    cyc = 0;
    while (w < 10 && cyc < 100) begin
      setIdle();
      stimValid[1] = 1'b1;
      stimAddr[1]  = AW'(PID);
      stimData[1]  = DW'(w);
      stimReady    = (cyc >= 12);
      applyStimulus();
      if (expGrant == 1) w++;
      cyc++;
    end
    if (w < 10) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL stream_timeout: accepted %0d words, expected 10", w);
    end
    idleCycles(10, 1'b1);

    // Foreign destinations are ignored while one word sits in the buffer.
    setIdle();
    stimReady    = 1'b0;
    stimValid[2] = 1'b1;
    stimAddr[2]  = AW'(PID);
    stimData[2]  = 8'h3C;
    applyStimulus();
    for (int c = 0; c < 4; c++) begin
      setIdle();
      stimReady    = 1'b0;
      stimValid[0] = 1'b1;
      stimValid[3] = 1'b1;
      stimAddr[0]  = 2'd1;
      stimAddr[3]  = 2'd1;
      applyStimulus();
    end
    idleCycles(3, 1'b1);

    // Load five words, start draining, reset mid-drain, then contend.
    for (int c = 0; c < 5; c++) begin
      setIdle();
      stimReady            = 1'b0;
      stimValid[(c+1)%NP]  = 1'b1;
      stimAddr[(c+1)%NP]   = AW'(PID);
    end
    for (int c = 0; c < 5; c++) begin
      setIdle();
      stimReady           = 1'b0;
      stimValid[(c+1)%NP] = 1'b1;
      stimAddr[(c+1)%NP]  = AW'(PID);
      applyStimulus();
    end
    idleCycles(2, 1'b1);
    setIdle();
    stimReset = 1'b1;
    applyStimulus();
    idleCycles(1, 1'b1);
    setIdle();
    for (int p = 0; p < NP; p++) begin
      stimValid[p] = 1'b1;
      stimAddr[p]  = AW'(PID);
    end
    applyStimulus();
    checkOutput("rr_restart_winner", 32'(expGrant), 32'd0);
    idleCycles(3, 1'b1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      setIdle();
      for (int p = 0; p < NP; p++) begin
        stimValid[p] = 1'($urandom_range(0, 1));
      end
      stimReady = ($urandom_range(0, 3) != 0);
      stimReset = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end
    idleCycles(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
